// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Register address/data widths and the hard-wired zero register index.
package regfile_wr_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 1 << REG_ADDR_W;
    localparam int unsigned REG_X0     = 0;

    function automatic bit isPow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_fifo.sv
// regarb_fifo: synchronous FIFO with power-of-two depth and occupancy count.
// A pop frees space for a same-cycle push even when the FIFO is full.
module regarb_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [Width-1:0]             wrData,
    output logic [Width-1:0]             rdData,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + CntW'(1);
            end else if (doPop && !doPush) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    assign rdData = mem[rdPtr];
    assign full   = (count == CntW'(Depth));
    assign empty  = (count == '0);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between pipeline writeback and a buffered
// long-latency unit, with a busy-bit scoreboard. Optional: REGARB_STARVE_GUARD_EN.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned Bitwidth    = REG_ADDR_W,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     wb_valid,
    input  logic [Bitwidth-1:0]      wb_rd,
    input  logic [2**Bitwidth-1:0]   wb_data,
    output logic                     wb_hold,

    input  logic                     lu_valid,
    input  logic [Bitwidth-1:0]      lu_rd,
    input  logic [2**Bitwidth-1:0]   lu_data,
    output logic                     lu_ready,

    input  logic                     issue_valid,
    input  logic [Bitwidth-1:0]      issue_rd,
    input  logic [Bitwidth-1:0]      chk_rs1,
    input  logic [Bitwidth-1:0]      chk_rs2,
    input  logic [Bitwidth-1:0]      chk_rd,
    output logic                     stall,

    output logic                     RegWrite,
    output logic [Bitwidth-1:0]      WriteRegister,
    output logic [2**Bitwidth-1:0]   WriteData
);

    localparam int unsigned DataW   = 2 ** Bitwidth;
    localparam int unsigned NumRegs = 2 ** Bitwidth;
    localparam int unsigned EntryW  = Bitwidth + DataW;
    localparam int unsigned CntW    = $clog2(FifoDepth + 1);

    if (!isPow2(FifoDepth) || (FifoDepth < 2) || (StarveLimit < 1)) begin : gBadParams
        $error("regfile_wr_arbiter: FifoDepth must be a power of two >= 2, StarveLimit >= 1");
    end

    logic                wbWrite;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [CntW-1:0]     fifoCount;
    logic [EntryW-1:0]   fifoRdData;
    logic [Bitwidth-1:0] headRd;
    logic [DataW-1:0]    headData;
    logic                forceHead;
    logic [NumRegs-1:0]  busy;
    logic [NumRegs-1:0]  busyNext;

    // Writes to x0 are architecturally dropped, so they leave the port idle.
    assign wbWrite  = wb_valid && (wb_rd != Bitwidth'(REG_X0));
    assign lu_ready = (fifoCount < CntW'(FifoDepth));
    assign fifoPush = lu_valid && lu_ready && (lu_rd != Bitwidth'(REG_X0));

    regarb_fifo #(
        .Depth (FifoDepth),
        .Width (EntryW)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData ({lu_rd, lu_data}),
        .rdData (fifoRdData),
        .count  (fifoCount),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    assign {headRd, headData} = fifoRdData;

`ifdef REGARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);

    logic [StarveW-1:0] starveCnt;

    // Counts cycles the head has been passed over; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (fifoPop) begin
            starveCnt <= '0;
        end else if (!fifoEmpty && (starveCnt != StarveW'(StarveLimit))) begin
            starveCnt <= starveCnt + StarveW'(1);
        end
    end

    assign forceHead = !fifoEmpty && (starveCnt == StarveW'(StarveLimit));
`else
    assign forceHead = 1'b0;
`endif

    // Write-port mux: starved head, then writeback, then FIFO head.
    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        fifoPop       = 1'b0;
        wb_hold       = 1'b0;
        if (!rst) begin
            if (forceHead) begin
                RegWrite      = 1'b1;
                WriteRegister = headRd;
                WriteData     = headData;
                fifoPop       = 1'b1;
                wb_hold       = wbWrite;
            end else if (wbWrite) begin
                RegWrite      = 1'b1;
                WriteRegister = wb_rd;
                WriteData     = wb_data;
            end else if (!fifoEmpty) begin
                RegWrite      = 1'b1;
                WriteRegister = headRd;
                WriteData     = headData;
                fifoPop       = 1'b1;
            end
        end
    end

    // Scoreboard update: the issue set is applied last so it wins over a clear.
    always_comb begin
        busyNext = busy;
        if (fifoPop) begin
            busyNext[headRd] = 1'b0;
        end
        if (issue_valid) begin
            busyNext[issue_rd] = 1'b1;
        end
        busyNext[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

    // Issue to a busy rd is only legal when that rd retires in the same cycle.
    issueToBusy: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && busy[issue_rd] && !(fifoPop && (headRd == issue_rd))));

    wawOnBusy: assert property (@(posedge clk) disable iff (rst)
        !(wbWrite && busy[wb_rd]));

    readyWhenFull: assert property (@(posedge clk) disable iff (rst)
        !(fifoFull && lu_ready));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table plus hand sequences, with a
// scoreboard of expected register-file writes checked on every falling edge.
module tb_regfile_wr_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_hold;
    logic          lu_valid;
    logic [AW-1:0] lu_rd;
    logic [DW-1:0] lu_data;
    logic          lu_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic [AW-1:0] chk_rd;
    logic          stall;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;

    regfile_wr_arbiter #(
        .Bitwidth    (AW),
        .FifoDepth   (2),
        .StarveLimit (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_hold       (wb_hold),
        .lu_valid      (lu_valid),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .chk_rs1       (chk_rs1),
        .chk_rs2       (chk_rs2),
        .chk_rd        (chk_rd),
        .stall         (stall),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          wbV;
        logic [AW-1:0] wbRd;
        logic [DW-1:0] wbD;
        logic [AW-1:0] c1;
        logic [AW-1:0] c2;
        logic [AW-1:0] c3;
        logic          expWe;
        logic [AW-1:0] expRd;
        logic [DW-1:0] expD;
        logic          expStall;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    wr_t  wbQ[$];
    wr_t  luQ[$];
    wr_t  monE;
    logic expectForce = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic driveWb(input logic [AW-1:0] rd, input logic [DW-1:0] d, input bit logIt);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        if (logIt && rd != '0) wbQ.push_back({rd, d});
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((luQ.size() != 0) && (n < budget)) begin
            cyc();
            n++;
        end
        check("drain_lu_queue", 32'(luQ.size()), 32'd0);
        check("drain_wb_queue", 32'(wbQ.size()), 32'd0);
    endtask

    // Record every accepted long-latency result in arrival order.
    always @(posedge clk) begin
        if (!rst && lu_valid && lu_ready && lu_rd != '0) luQ.push_back({lu_rd, lu_data});
    end

    // Every write the DUT makes must match the next expected one.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_no_write", 32'(RegWrite), 32'd0);
        end else if (wb_valid && wb_rd != '0 && !expectForce) begin
            if (wbQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_scoreboard: wb rd=%0d present but no write expected", wb_rd);
            end else begin
                monE = wbQ.pop_front();
                check("wb_write_en", 32'(RegWrite), 32'd1);
                check("wb_write_rd", 32'(WriteRegister), 32'(monE.rd));
                check("wb_write_data", WriteData, monE.data);
            end
        end else if (RegWrite) begin
            if (luQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: rd=%0d data=0x%08h with nothing pending",
                         WriteRegister, WriteData);
            end else begin
                monE = luQ.pop_front();
                check("lu_write_rd", 32'(WriteRegister), 32'(monE.rd));
                check("lu_write_data", WriteData, monE.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   idx;
        int   k;
        int   holdCyc;
        bit   acc;

        vecs[0] = '{1'b1, 5'd3,  32'h1111_1111, 5'd1,  5'd2,  5'd4,  1'b1, 5'd3,  32'h1111_1111, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_FFFF, 5'd10, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1};
        vecs[2] = '{1'b0, 5'd7,  32'h7777_7777, 5'd0,  5'd11, 5'd0,  1'b0, 5'd0,  32'h0,         1'b1};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd0,  5'd0,  5'd11, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd12, 5'd13, 5'd0,  1'b1, 5'd1,  32'h0000_0001, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0};

        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        #3;
        check("reset_regwrite", 32'(RegWrite), 32'd0);
        check("reset_lu_ready", 32'(lu_ready), 32'd1);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_wb_hold", 32'(wb_hold), 32'd0);

        // Issue x5, see the stall, then retire it through the FIFO.
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd5;
        cyc();
        issue_valid = 1'b0; chk_rs1 = 5'd5;
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
        #3;
        check("stall_after_issue", 32'(stall), 32'd1);
        cyc();
        lu_valid = 1'b0;
        #3;
        check("lu_latency_we", 32'(RegWrite), 32'd1);
        check("lu_latency_rd", 32'(WriteRegister), 32'd5);
        check("lu_latency_data", WriteData, 32'hDEAD_BEEF);
        check("stall_in_write_cycle", 32'(stall), 32'd1);
        cyc();
        #3;
        check("stall_after_write", 32'(stall), 32'd0);
        check("idle_after_write", 32'(RegWrite), 32'd0);

        // Vector table with x10 and x11 busy.
        cyc();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd10;
        cyc();
        issue_rd = 5'd11;
        cyc();
        issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wbV) begin
                driveWb(vecs[i].wbRd, vecs[i].wbD, 1'b1);
            end else begin
                wb_valid = 1'b0; wb_rd = vecs[i].wbRd; wb_data = vecs[i].wbD;
            end
            chk_rs1 = vecs[i].c1; chk_rs2 = vecs[i].c2; chk_rd = vecs[i].c3;
            #3;
            check($sformatf("vec%0d_we", i), 32'(RegWrite), 32'(vecs[i].expWe));
            check($sformatf("vec%0d_rd", i), 32'(WriteRegister), 32'(vecs[i].expRd));
            check($sformatf("vec%0d_data", i), WriteData, vecs[i].expD);
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
            cyc();
        end
        idle();
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h0000_0010;
        cyc();
        lu_rd = 5'd11; lu_data = 32'h0000_0011;
        cyc();
        lu_valid = 1'b0;
        cyc();
        chk_rs1 = 5'd10; chk_rs2 = 5'd11;
        #3;
        check("table_busy_cleared", 32'(stall), 32'd0);
        waitDrain(8);

        // Continuous writeback while three results queue behind a depth-2 FIFO.
        cyc();
        idle();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) driveWb(5'(c + 1), 32'h100 + 32'(c), 1'b1);
            else wb_valid = 1'b0;
            if (idx < 3) begin
                lu_valid = 1'b1; lu_rd = 5'(20 + idx); lu_data = 32'hB000 + 32'(idx);
            end else begin
                lu_valid = 1'b0;
            end
            #3;
            if (c == 2) check("lu_ready_full", 32'(lu_ready), 32'd0);
            if (c == 8) check("lu_ready_full_pop", 32'(lu_ready), 32'd0);
            if (c == 9) check("lu_ready_after_pop", 32'(lu_ready), 32'd1);
            acc = lu_valid && lu_ready;
            cyc();
            if (acc) idx++;
        end
        check("all_lu_accepted", 32'(idx), 32'd3);
        waitDrain(8);

        // x0 handling: lu to x0 is discarded, wb to x0 lets the FIFO drain.
        idle();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h0000_0099;
        cyc();
        lu_valid = 1'b0;
        #3;
        check("lu_x0_discard", 32'(RegWrite), 32'd0);
        check("lu_x0_ready", 32'(lu_ready), 32'd1);
        cyc();
        driveWb(5'd2, 32'h0000_0022, 1'b1);
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_0077;
        cyc();
        driveWb(5'd3, 32'h0000_0033, 1'b1);
        lu_valid = 1'b0;
        #3;
        check("wb_beats_fifo", 32'(WriteRegister), 32'd3);
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        #3;
        check("wb_x0_drain_we", 32'(RegWrite), 32'd1);
        check("wb_x0_drain_rd", 32'(WriteRegister), 32'd7);
        check("wb_x0_drain_data", WriteData, 32'h0000_0077);
        cyc();
        idle();
        #3;
        check("x0_idle_after", 32'(RegWrite), 32'd0);
        waitDrain(4);

        // Re-issue x9 in the same cycle its older result retires.
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        issue_valid = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_009A;
        driveWb(5'd2, 32'h0000_0202, 1'b1);
        cyc();
        lu_valid = 1'b0;
        driveWb(5'd4, 32'h0000_0404, 1'b1);
        cyc();
        wb_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #3;
        check("x9_pop_we", 32'(RegWrite), 32'd1);
        check("x9_pop_rd", 32'(WriteRegister), 32'd9);
        cyc();
        issue_valid = 1'b0; chk_rs1 = 5'd9;
        #3;
        check("set_wins_over_clear", 32'(stall), 32'd1);
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_009B;
        cyc();
        lu_valid = 1'b0;
        cyc();
        #3;
        check("x9_cleared", 32'(stall), 32'd0);
        waitDrain(4);

        // One queued entry under continuous writeback.
`ifdef REGARB_STARVE_GUARD_EN
        holdCyc = 5;
`else
        holdCyc = -1;
`endif
        cyc();
        idle();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            lu_valid = (c == 0); lu_rd = 5'd14; lu_data = 32'h0000_0E14;
            if (c == holdCyc) begin
                expectForce = 1'b1;
                driveWb(5'(16 + k), 32'h5000 + 32'(k), 1'b0);
            end else begin
                expectForce = 1'b0;
                driveWb(5'(16 + k), 32'h5000 + 32'(k), 1'b1);
                k++;
            end
            #3;
            check($sformatf("starve_hold_c%0d", c), 32'(wb_hold), 32'(c == holdCyc));
            if (c == holdCyc) check("starve_head_rd", 32'(WriteRegister), 32'd14);
            if (c == holdCyc + 1) check("held_wb_rd", 32'(WriteRegister), 32'(16 + k - 1));
            cyc();
        end
        expectForce = 1'b0;
        idle();
        waitDrain(6);

        // Reset while the FIFO is full and x25 is busy.
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd25;
        cyc();
        issue_valid = 1'b0;
        driveWb(5'd1, 32'h0000_0A01, 1'b1);
        lu_valid = 1'b1; lu_rd = 5'd26; lu_data = 32'h0000_0026;
        cyc();
        driveWb(5'd2, 32'h0000_0A02, 1'b1);
        lu_rd = 5'd27; lu_data = 32'h0000_0027;
        cyc();
        driveWb(5'd3, 32'h0000_0A03, 1'b1);
        lu_valid = 1'b0; chk_rs1 = 5'd25;
        #3;
        check("full_before_rst", 32'(lu_ready), 32'd0);
        check("busy_before_rst", 32'(stall), 32'd1);
        cyc();
        rst = 1'b1;
        idle();
        #3;
        check("rst_mid_no_write", 32'(RegWrite), 32'd0);
        cyc();
        rst = 1'b0;
        luQ.delete();
        chk_rs1 = 5'd25;
        #3;
        check("post_rst_we", 32'(RegWrite), 32'd0);
        check("post_rst_ready", 32'(lu_ready), 32'd1);
        check("post_rst_stall", 32'(stall), 32'd0);
        repeat (3) cyc();
        #3;
        check("post_rst_still_idle", 32'(RegWrite), 32'd0);
        waitDrain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
